// File: rtl/nes_pad_reader_pkg.sv
// nes_pad_reader_pkg: codes shared between the gamepad reader and the
// Bomberman movement logic (direction codes, button bit positions) plus the
// reader FSM state encoding and the direction priority helper.
package nes_pad_reader_pkg;

    // Current-direction codes consumed by the movement logic
    localparam logic [1:0] CD_U = 2'b00;
    localparam logic [1:0] CD_R = 2'b01;
    localparam logic [1:0] CD_D = 2'b10;
    localparam logic [1:0] CD_L = 2'b11;

    // Bit positions inside the button byte, in pad shift order
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Reader FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Picks one direction out of a set indexed by direction code,
    // priority Up > Right > Down > Left. Only meaningful for a non-empty set.
    function automatic logic [1:0] pick_dir(input logic [3:0] dirs);
        logic [1:0] code;
        code = CD_L;
        if (dirs[CD_D]) code = CD_D;
        if (dirs[CD_R]) code = CD_R;
        if (dirs[CD_U]) code = CD_U;
        return code;
    endfunction

endpackage

// File: rtl/nes_dir_tracker.sv
// nes_dir_tracker: turns a button byte into masked direction holds and the
// current-direction code. Everything updates only on the valid strobe.
// Opposite directions pressed together cancel each other out.
module nes_dir_tracker
    import nes_pad_reader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons_i,
    input  logic       valid_i,
    output logic       L_o,
    output logic       R_o,
    output logic       U_o,
    output logic       D_o,
    output logic [1:0] cd_o
);

    // Held directions indexed by direction code (bit CD_U is Up, etc.)
    logic [3:0] held_q, held_d;
    logic [3:0] fresh;
    logic [1:0] cd_q, cd_d;
    logic       unusedButtons;

    assign unusedButtons = ^buttons_i[BTN_START:BTN_A];

    // Mask opposite pairs, then pick the new direction: a freshly pressed
    // one wins, otherwise fall back to another held one if ours was released
    always_comb begin
        held_d       = '0;
        held_d[CD_U] = buttons_i[BTN_UP]    & ~buttons_i[BTN_DOWN];
        held_d[CD_D] = buttons_i[BTN_DOWN]  & ~buttons_i[BTN_UP];
        held_d[CD_L] = buttons_i[BTN_LEFT]  & ~buttons_i[BTN_RIGHT];
        held_d[CD_R] = buttons_i[BTN_RIGHT] & ~buttons_i[BTN_LEFT];
        fresh        = held_d & ~held_q;
        cd_d         = cd_q;
        if (|fresh) begin
            cd_d = pick_dir(fresh);
        end else if (!held_d[cd_q] && (|held_d)) begin
            cd_d = pick_dir(held_d);
        end
    end

    // Register the masked holds and direction code on each completed read
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q <= '0;
            cd_q   <= CD_D;
        end else if (valid_i) begin
            held_q <= held_d;
            cd_q   <= cd_d;
        end
    end

    assign U_o  = held_q[CD_U];
    assign R_o  = held_q[CD_R];
    assign D_o  = held_q[CD_D];
    assign L_o  = held_q[CD_L];
    assign cd_o = cd_q;

endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls a NES serial gamepad at a fixed rate, deserialises
// its 8 active-low button bits and feeds the direction tracker.
// Optional macro DEBOUNCE_EN: a button bit only changes once two consecutive
// completed reads agree on it.
module nes_pad_reader
    import nes_pad_reader_pkg::*;
#(
    parameter int unsigned POLL_DIV  = 1666667,
    parameter int unsigned LATCH_CYC = 1200,
    parameter int unsigned HALF_BIT  = 600
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       ctrl_data,
    output logic       ctrl_latch,
    output logic       ctrl_clk,
    output logic [7:0] buttons,
    output logic       L,
    output logic       R,
    output logic       U,
    output logic       D,
    output logic [1:0] cd,
    output logic       btn_valid
);

    localparam int unsigned PW   = $clog2(POLL_DIV);
    localparam int unsigned TMAX = (LATCH_CYC > HALF_BIT) ? LATCH_CYC : HALF_BIT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    logic [PW-1:0] pollCnt_q;
    logic          pollTick;
    logic [1:0]    sync_q;
    logic          dataSync;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] phase_q, phase_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic          latch_q, sclk_q;
    logic [7:0]    buttons_q;
    logic [7:0]    newButtons;
    logic          valid_q;
    logic          doneStrobe;

    assign pollTick   = (pollCnt_q == PW'(POLL_DIV - 1));
    assign dataSync   = sync_q[1];
    assign doneStrobe = (state_q == ST_DONE);

    // Free-running poll timer; reads never pause it
    always_ff @(posedge clk) begin
        if (reset || pollTick) begin
            pollCnt_q <= '0;
        end else begin
            pollCnt_q <= pollCnt_q + PW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous pad data line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ctrl_data};
        end
    end

    // Latch pulse, then eight low/high clock phases sampling at the end of each low
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + TW'(1);
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (pollTick) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (phase_q == TW'(LATCH_CYC - 1)) begin
                    phase_d  = '0;
                    bitIdx_d = '0;
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_q == TW'(HALF_BIT - 1)) begin
                    phase_d           = '0;
                    shift_d[bitIdx_q] = ~dataSync;
                    state_d           = (bitIdx_q == 3'd7) ? ST_DONE : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_q == TW'(HALF_BIT - 1)) begin
                    phase_d  = '0;
                    bitIdx_d = bitIdx_q + 3'd1;
                    state_d  = ST_LOW;
                end
            end
            ST_DONE: begin
                phase_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                phase_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state plus glitch-free registered pad strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            latch_q  <= 1'b0;
            sclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            latch_q  <= (state_d == ST_LATCH);
            sclk_q   <= (state_d == ST_HIGH);
        end
    end

`ifdef DEBOUNCE_EN
    logic [7:0] hist_q;

    assign newButtons = (~(shift_q ^ hist_q) & shift_q) | ((shift_q ^ hist_q) & buttons_q);

    // Remember the previous raw read so single-read glitches are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else if (doneStrobe) begin
            hist_q <= shift_q;
        end
    end
`else
    assign newButtons = shift_q;
`endif

    // Publish the new button byte and the valid pulse together
    always_ff @(posedge clk) begin
        if (reset) begin
            buttons_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= doneStrobe;
            if (doneStrobe) buttons_q <= newButtons;
        end
    end

    nes_dir_tracker u_dirTracker (
        .clk       (clk),
        .reset     (reset),
        .buttons_i (newButtons),
        .valid_i   (doneStrobe),
        .L_o       (L),
        .R_o       (R),
        .U_o       (U),
        .D_o       (D),
        .cd_o      (cd)
    );

    assign ctrl_latch = latch_q;
    assign ctrl_clk   = sclk_q;
    assign buttons    = buttons_q;
    assign btn_valid  = valid_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: drives nes_pad_reader with a behavioural NES pad and
// compares every completed read against a rule-level reference model.
// Honours DEBOUNCE_EN the same way as the design.
module tb_nes_pad_reader;

    localparam int POLL_DIV  = 200;
    localparam int LATCH_CYC = 8;
    localparam int HALF_BIT  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ctrl_data;
    logic       ctrl_latch, ctrl_clk;
    logic [7:0] buttons;
    logic       L, R, U, D;
    logic [1:0] cd;
    logic       btn_valid;

    int checks = 0;
    int failures = 0;

    logic [7:0] padPressed = 8'h00;
    logic [7:0] padShift = 8'hFF;

    // Reference model state; held bits indexed 0=Up 1=Right 2=Down 3=Left
    logic [7:0] expButtons;
    logic [3:0] expHeld;
    logic [1:0] expCd;
    logic [7:0] expHist;

    nes_pad_reader #(
        .POLL_DIV  (POLL_DIV),
        .LATCH_CYC (LATCH_CYC),
        .HALF_BIT  (HALF_BIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_data  (ctrl_data),
        .ctrl_latch (ctrl_latch),
        .ctrl_clk   (ctrl_clk),
        .buttons    (buttons),
        .L          (L),
        .R          (R),
        .U          (U),
        .D          (D),
        .cd         (cd),
        .btn_valid  (btn_valid)
    );

    always #5 clk = ~clk;

    // Pad model: parallel load on latch, shift towards bit 0 on each clock rise
    always @(posedge ctrl_latch or posedge ctrl_clk) begin
        if (ctrl_latch) padShift = ~padPressed;
        else            padShift = {1'b1, padShift[7:1]};
    end
    assign ctrl_data = padShift[0];

    function automatic logic [3:0] dutDirs();
        return {L, D, R, U};
    endfunction

    function automatic logic [1:0] firstDir(input logic [3:0] set);
        for (int i = 0; i < 4; i++) if (set[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic modelReset();
        expButtons = 8'h00;
        expHeld    = 4'h0;
        expCd      = 2'd2;
        expHist    = 8'h00;
    endtask

    task automatic modelRead(input logic [7:0] pressed);
        logic [7:0] deb;
        logic [3:0] held, fresh;
        logic       up, down, left, right;
`ifdef DEBOUNCE_EN
        for (int b = 0; b < 8; b++) deb[b] = (pressed[b] == expHist[b]) ? pressed[b] : expButtons[b];
        expHist = pressed;
`else
        deb = pressed;
`endif
        up    = deb[4];
        down  = deb[5];
        left  = deb[6];
        right = deb[7];
        held[0] = up && !down;
        held[1] = right && !left;
        held[2] = down && !up;
        held[3] = left && !right;
        fresh = held & ~expHeld;
        if (fresh != 0) expCd = firstDir(fresh);
        else if (!held[expCd] && held != 0) expCd = firstDir(held);
        expHeld    = held;
        expButtons = deb;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // One full poll: present a pad state, wait for the read, compare results
    task automatic waitRead(input logic [7:0] pressed, input string tag);
        logic [7:0] oldButtons;
        logic [3:0] oldHeld;
        logic [1:0] oldCd;
        bit seen, moved;
        oldButtons = expButtons;
        oldHeld    = expHeld;
        oldCd      = expCd;
        padPressed = pressed;
        modelRead(pressed);
        seen  = 0;
        moved = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (btn_valid) seen = 1;
            else if (buttons !== oldButtons || dutDirs() !== oldHeld || cd !== oldCd) moved = 1;
        end
        checks++;
        if (moved) begin
            failures++;
            $display("[TB] FAIL %s_hold: outputs changed between reads, expected %h/%h/%0d", tag, oldButtons, oldHeld, oldCd);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL %s_timeout: btn_valid=0 after 400 cycles, expected 1", tag);
            return;
        end
        checks++;
        if (buttons !== expButtons) begin
            failures++;
            $display("[TB] FAIL %s_buttons: got %h expected %h", tag, buttons, expButtons);
        end
        checks++;
        if (dutDirs() !== expHeld) begin
            failures++;
            $display("[TB] FAIL %s_dirs: got LDRU=%b expected %b", tag, dutDirs(), expHeld);
        end
        checks++;
        if (cd !== expCd) begin
            failures++;
            $display("[TB] FAIL %s_cd: got %b expected %b", tag, cd, expCd);
        end
        @(negedge clk);
        checks++;
        if (btn_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_pulse: btn_valid=%b one cycle later, expected 0", tag, btn_valid);
        end
    endtask

    task automatic test_reset();
        int latchFirst, latchCnt, clkRises, clkHigh, validAt, validCnt;
        logic prevClk;
        padPressed = 8'h00;
        doReset();
        checks++;
        if ({ctrl_latch, ctrl_clk, btn_valid} !== 3'b000 || buttons !== 8'h00 || dutDirs() !== 4'h0 || cd !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_values: got latch=%b clk=%b valid=%b buttons=%h LDRU=%b cd=%b expected 0 0 0 00 0000 10",
                     ctrl_latch, ctrl_clk, btn_valid, buttons, dutDirs(), cd);
        end
        latchFirst = -1; latchCnt = 0; clkRises = 0; clkHigh = 0; validAt = -1; validCnt = 0;
        prevClk = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (ctrl_latch) begin
                latchCnt++;
                if (latchFirst < 0) latchFirst = i;
            end
            if (ctrl_clk) begin
                clkHigh++;
                if (!prevClk) clkRises++;
            end
            prevClk = ctrl_clk;
            if (btn_valid) begin
                validCnt++;
                if (validAt < 0) validAt = i;
            end
        end
        modelRead(8'h00);
        checks++;
        if (latchFirst != POLL_DIV || latchCnt != LATCH_CYC) begin
            failures++;
            $display("[TB] FAIL latch_timing: got first=%0d count=%0d expected %0d %0d", latchFirst, latchCnt, POLL_DIV, LATCH_CYC);
        end
        checks++;
        if (clkRises != 7 || clkHigh != 7 * HALF_BIT) begin
            failures++;
            $display("[TB] FAIL clk_pulses: got rises=%0d high=%0d expected 7 %0d", clkRises, clkHigh, 7 * HALF_BIT);
        end
        checks++;
        if (validAt != POLL_DIV - 1 + 1 + LATCH_CYC + 15 * HALF_BIT + 1 || validCnt != 1) begin
            failures++;
            $display("[TB] FAIL valid_latency: got at=%0d count=%0d expected %0d 1", validAt, validCnt,
                     POLL_DIV + LATCH_CYC + 15 * HALF_BIT + 1);
        end
        checks++;
        if (buttons !== expButtons || cd !== expCd || dutDirs() !== expHeld) begin
            failures++;
            $display("[TB] FAIL idle_read: got buttons=%h cd=%b LDRU=%b expected %h %b %b", buttons, cd, dutDirs(), expButtons, expCd, expHeld);
        end
    endtask

    task automatic test_a_right();
        waitRead(8'h81, "a_right");
        waitRead(8'h81, "a_right2");
    endtask

    task automatic test_cd_sequence();
        logic [7:0] seq [8] = '{8'h10, 8'h10, 8'h50, 8'h50, 8'h10, 8'h10, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) waitRead(seq[i], "cd_seq");
    endtask

    task automatic test_opposite_mask();
        waitRead(8'hB0, "opposite");
        waitRead(8'hB0, "opposite2");
        waitRead(8'hC1, "opposite_lr");
        waitRead(8'hC1, "opposite_lr2");
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        int rises, pulses;
        logic prevClk;
        padPressed = 8'h5A;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (ctrl_latch) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL midreset_latch: ctrl_latch=0 after 400 cycles, expected 1");
        end
        rises = 0;
        prevClk = 1'b0;
        for (int i = 0; i < 200 && rises < 4; i++) begin
            @(negedge clk);
            if (ctrl_clk && !prevClk) rises++;
            prevClk = ctrl_clk;
        end
        checks++;
        if (rises != 4) begin
            failures++;
            $display("[TB] FAIL midreset_rises: got %0d clock rises expected 4", rises);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ctrl_clk !== 1'b0 || ctrl_latch !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_drop: got clk=%b latch=%b expected 0 0", ctrl_clk, ctrl_latch);
        end
        reset = 1'b0;
        modelReset();
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (btn_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || buttons !== 8'h00 || cd !== 2'b10 || dutDirs() !== 4'h0) begin
            failures++;
            $display("[TB] FAIL midreset_discard: got pulses=%0d buttons=%h cd=%b LDRU=%b expected 0 00 10 0000",
                     pulses, buttons, cd, dutDirs());
        end
        waitRead(8'h5A, "after_reset");
        waitRead(8'h5A, "after_reset2");
    endtask

    task automatic test_debounce();
`ifdef DEBOUNCE_EN
        doReset();
        waitRead(8'h08, "deb_once");
        checks++;
        if (buttons[3] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL deb_single: got start=%b expected 0", buttons[3]);
        end
        waitRead(8'h00, "deb_clear");
        waitRead(8'h08, "deb_first");
        waitRead(8'h08, "deb_second");
        checks++;
        if (buttons[3] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL deb_double: got start=%b expected 1", buttons[3]);
        end
`else
        waitRead(8'h08, "start_once");
        waitRead(8'h00, "start_off");
`endif
    endtask

    task automatic test_random();
        logic [7:0] v;
        v = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0) v = 8'($urandom);
            waitRead(v, "random");
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_a_right();
        test_cd_sequence();
        test_opposite_mask();
        test_reset_mid_read();
        test_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
